// File: rtl/regfile_pkg.sv
// Shared defaults, index/data types and helpers for the regfile_sb register file.
package regfile_pkg;
  localparam int XLEN_D   = 32;
  localparam int NREG_D   = 32;
  localparam int NUM_RD_D = 2;
  localparam int AW_D     = $clog2(NREG_D);

  typedef logic [AW_D-1:0]   reg_idx_t;
  typedef logic [XLEN_D-1:0] xword_t;

  // Callers zero-extend their index so the helper works for any register count.
  function automatic logic is_zero_reg(input logic [31:0] idx);
    return (idx == 32'd0);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG     = NREG_D,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_vld,
  input  logic [AW-1:0]   issue_rd,
  input  logic            regwr,
  input  logic [AW-1:0]   rw,
  output logic [NREG-1:0] pend,
  output logic [AW:0]     pend_cnt,
  output logic            any_pend
);
  logic set_en;
  logic set_new;
  logic clr_eff;

  // Count deltas only reflect real bit transitions, so the count never drifts from popcount.
  always_comb begin
    set_en  = issue_vld && ((ZERO_REG == 0) || !is_zero_reg(32'(issue_rd)));
    set_new = set_en && !pend[issue_rd];
    clr_eff = regwr && pend[rw] && !(set_en && (issue_rd == rw));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (regwr)  pend[rw]       <= 1'b0;
      // Issued later so a same-register set overrides the writeback clear.
      if (set_en) pend[issue_rd] <= 1'b1;
      pend_cnt <= pend_cnt + (AW+1)'(set_new) - (AW+1)'(clr_eff);
    end
  end

  assign any_pend = (pend_cnt != '0);
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with async read ports, one sync write port and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_D,
  parameter  int NREG     = NREG_D,
  parameter  int NUM_RD   = NUM_RD_D,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   ra,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   regwr,
  input  logic [AW-1:0]          rw,
  input  logic [XLEN-1:0]        busw,
  input  logic                   issue_vld,
  input  logic [AW-1:0]          issue_rd,
  output logic [AW:0]            pend_cnt,
  output logic                   any_pend
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic            wr_ok;

  assign wr_ok = regwr && ((ZERO_REG == 0) || !is_zero_reg(32'(rw)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (wr_ok) begin
      regs[rw] <= busw;
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .regwr     (regwr),
    .rw        (rw),
    .pend      (pend),
    .pend_cnt  (pend_cnt),
    .any_pend  (any_pend)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   ra_i;
    logic [XLEN-1:0] rd_i;
    logic            busy_i;
    logic            zero_i;

    assign ra_i   = ra[i*AW +: AW];
    assign zero_i = (ZERO_REG != 0) && is_zero_reg(32'(ra_i));

    always_comb begin
      rd_i   = regs[ra_i];
      busy_i = pend[ra_i];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle re-issue of the written register keeps the reader stalled.
      if (wr_ok && (rw == ra_i)) begin
        rd_i   = busw;
        busy_i = issue_vld && (issue_rd == rw);
      end
`endif
      if (zero_i) begin
        rd_i   = '0;
        busy_i = 1'b0;
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd_i;
    assign rd_busy[i]            = busy_i;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb at default parameters (ZERO_REG=1).
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] ra;
  logic [63:0]   rdata;
  logic [1:0]    rd_busy;
  logic          regwr;
  logic [AW-1:0] rw;
  xword_t        busw;
  logic          issue_vld;
  logic [AW-1:0] issue_rd;
  logic [AW:0]   pend_cnt;
  logic          any_pend;

  int checks   = 0;
  int failures = 0;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .ra        (ra),
    .rdata     (rdata),
    .rd_busy   (rd_busy),
    .regwr     (regwr),
    .rw        (rw),
    .busw      (busw),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .pend_cnt  (pend_cnt),
    .any_pend  (any_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          regwr;
    logic [AW-1:0] rw;
    xword_t        busw;
    logic          iv;
    logic [AW-1:0] ird;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    xword_t        e0;
    xword_t        e1;
    logic [1:0]    ebusy;
    logic [AW:0]   ecnt;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t mk(input logic w, input int wr, input xword_t d, input logic iv,
                              input int ird, input int a0, input int a1, input xword_t e0,
                              input xword_t e1, input logic [1:0] eb, input int ec);
    vec_t v;
    v.regwr = w;   v.rw = AW'(wr);   v.busw = d;
    v.iv = iv;     v.ird = AW'(ird);
    v.ra0 = AW'(a0); v.ra1 = AW'(a1);
    v.e0 = e0;     v.e1 = e1;     v.ebusy = eb;  v.ecnt = (AW+1)'(ec);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input int wr, input xword_t d, input logic iv,
                       input int ird, input int a0, input int a1);
    regwr = w; rw = AW'(wr); busw = d; issue_vld = iv; issue_rd = AW'(ird);
    ra = {AW'(a1), AW'(a0)};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input xword_t e0, input xword_t e1,
                             input logic [1:0] eb, input int ec);
    chk({tag, ".rdata0"}, 64'(rdata[31:0]), 64'(e0));
    chk({tag, ".rdata1"}, 64'(rdata[63:32]), 64'(e1));
    chk({tag, ".rd_busy"}, 64'(rd_busy), 64'(eb));
    chk({tag, ".pend_cnt"}, 64'(pend_cnt), 64'(ec));
    chk({tag, ".any_pend"}, 64'(any_pend), 64'(ec != 0));
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0, 0);

    // Vector semantics: outputs checked before the edge that commits the vector's inputs.
    vt[0]  = mk(1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 32'h0,    32'h0,    2'b00, 0);
    vt[1]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,    2'b00, 0);
    vt[2]  = mk(0, 0, 32'h0,        1, 5, 5, 0, 32'h0,    32'h0,    2'b00, 0);
    vt[3]  = mk(0, 0, 32'h0,        0, 0, 5, 1, 32'h0,    32'h0,    2'b01, 1);
    vt[4]  = mk(1, 5, 32'h1234,     0, 0, 1, 2, 32'h0,    32'h0,    2'b00, 1);
    vt[5]  = mk(0, 0, 32'h0,        0, 0, 5, 0, 32'h1234, 32'h0,    2'b00, 0);
    vt[6]  = mk(0, 0, 32'h0,        1, 7, 5, 7, 32'h1234, 32'h0,    2'b00, 0);
    vt[7]  = mk(1, 7, 32'h77,       1, 7, 5, 5, 32'h1234, 32'h1234, 2'b00, 1);
    vt[8]  = mk(0, 0, 32'h0,        0, 0, 7, 5, 32'h77,   32'h1234, 2'b01, 1);
    vt[9]  = mk(0, 0, 32'h0,        1, 3, 0, 0, 32'h0,    32'h0,    2'b00, 1);
    vt[10] = mk(1, 3, 32'h333,      1, 9, 9, 7, 32'h0,    32'h77,   2'b10, 2);
    vt[11] = mk(0, 0, 32'h0,        0, 0, 9, 3, 32'h0,    32'h333,  2'b01, 2);
    vt[12] = mk(1, 7, 32'h88,       0, 0, 9, 9, 32'h0,    32'h0,    2'b11, 2);
    vt[13] = mk(0, 0, 32'h0,        0, 0, 7, 3, 32'h88,   32'h333,  2'b00, 1);
    vt[14] = mk(1, 12, 32'hCC,      0, 0, 9, 0, 32'h0,    32'h0,    2'b01, 1);
    vt[15] = mk(0, 0, 32'h0,        1, 9, 12, 9, 32'hCC,  32'h0,    2'b10, 1);
    vt[16] = mk(0, 0, 32'h0,        0, 0, 9, 12, 32'h0,   32'hCC,   2'b01, 1);

    #3;
    chk_outputs("reset", 32'h0, 32'h0, 2'b00, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drive(vt[i].regwr, int'(vt[i].rw), vt[i].busw, vt[i].iv, int'(vt[i].ird),
            int'(vt[i].ra0), int'(vt[i].ra1));
      @(negedge clk);
      chk_outputs($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].ebusy, int'(vt[i].ecnt));
    end

    // Write 0x11 to r4 while issuing r4: set wins, r4 becomes pending.
    next_cycle();
    drive(1, 4, 32'h11, 1, 4, 12, 12);
    @(negedge clk);
    chk_outputs("byp_pre", 32'hCC, 32'hCC, 2'b00, 1);
    next_cycle();
    drive(1, 4, 32'hA5A5A5A5, 0, 0, 4, 4);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk_outputs("byp_same", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 2);
`else
    chk_outputs("byp_same", 32'h11, 32'h11, 2'b11, 2);
`endif
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 4, 4);
    @(negedge clk);
    chk_outputs("byp_next", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1);
    // Write plus re-issue of r4: forwarded data, but the reader stays stalled.
    next_cycle();
    drive(1, 4, 32'hBB, 1, 4, 4, 4);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk_outputs("byp_reissue", 32'hBB, 32'hBB, 2'b11, 1);
`else
    chk_outputs("byp_reissue", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1);
`endif
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 4, 5);
    @(negedge clk);
    chk_outputs("byp_reissue_next", 32'hBB, 32'h1234, 2'b01, 2);

    // Asynchronous reset between edges clears everything immediately.
    #2;
    rst = 1'b0;
    #1;
    chk_outputs("async_rst", 32'h0, 32'h0, 2'b00, 0);
    @(negedge clk);
    rst = 1'b1;

    // Fill every writable register, including a no-op issue to x0 and a repeat issue.
    for (int r = 0; r < 32; r++) begin
      next_cycle();
      drive(0, 0, 32'h0, 1, r, 0, 0);
    end
    next_cycle();
    drive(0, 0, 32'h0, 1, 31, 0, 31);
    @(negedge clk);
    chk_outputs("fill", 32'h0, 32'h0, 2'b10, 31);
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 0, 31);
    @(negedge clk);
    chk_outputs("fill_nowrap", 32'h0, 32'h0, 2'b10, 31);

    for (int r = 1; r < 32; r++) begin
      next_cycle();
      drive(1, r, 32'(r * 3), 0, 0, 0, 0);
    end
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 30, 31);
    @(negedge clk);
    chk_outputs("drain", 32'd90, 32'd93, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
